// File: rtl/keypad_scan_unit_pkg.sv
// keypad_scan_unit_pkg: shared key codes, 7-segment glyphs and scanner types
package keypad_scan_unit_pkg;
    localparam logic [3:0] KEY_NONE  = 4'hF;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {UNLOCKED, LOCKED} scan_state_t;

    function automatic logic [1:0] col_index(input logic [2:0] column);
        return column == 3'b110 ? 2'd0 : column == 3'b101 ? 2'd1 : 2'd2;
    endfunction
endpackage

// File: rtl/keypad_scan_unit_if.sv
// keypad_scan_unit_if: keypad matrix lines plus the debounced key report
interface keypad_scan_unit_if;
    logic [2:0] row;
    logic [2:0] column;
    logic       valid_key;
    logic [3:0] key;
    logic [6:0] key_hex;
    modport master (input row, output column, valid_key, key, key_hex);
    modport slave (output row, input column, valid_key, key, key_hex);
endinterface

// File: rtl/keypad_scan_unit_seg7_digit_decoder.sv
// seg7_digit_decoder: binary digit to active-low 7-segment pattern, blank above 9
module seg7_digit_decoder
    import keypad_scan_unit_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/keypad_scan_unit.sv
// keypad_scan_unit: 3x3 matrix column scanner with press/release debounce and key display
module keypad_scan_unit
    import keypad_scan_unit_pkg::*;
#(
    parameter logic [27:0] SCAN_MAX       = 28'd49_999,
    parameter logic [2:0]  DEBOUNCE_SCANS = 3'd4
) (
    input  logic               clk,
    input  logic               reset,
    keypad_scan_unit_if.master kp
);
    logic [27:0] div;
    logic        tick;
    logic [2:0]  column;
    logic [1:0]  col;
    logic        has_cand;
    logic [1:0]  cand_row;
    scan_state_t state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [1:0]  r_q, r_n, c_q, c_n;
    logic [3:0]  key_q, key_n;
    logic        valid_q, valid_n;

    assign tick     = div == 28'd0;
    assign col      = col_index(column);
    assign has_cand = kp.row != 3'b111;
    assign cand_row = !kp.row[0] ? 2'd0 : !kp.row[1] ? 2'd1 : 2'd2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div    <= SCAN_MAX;
            column <= 3'b110;
        end else begin
            div    <= tick ? SCAN_MAX : div - 28'd1;
            column <= tick ? {column[1:0], column[2]} : column;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= UNLOCKED;
            cnt     <= 3'd0;
            r_q     <= 2'd0;
            c_q     <= 2'd0;
            key_q   <= KEY_NONE;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            r_q     <= r_n;
            c_q     <= c_n;
            key_q   <= key_n;
            valid_q <= valid_n;
        end
    end

    // r_q/c_q hold the candidate being debounced, and the locked key once accepted
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        r_n     = r_q;
        c_n     = c_q;
        key_n   = key_q;
        valid_n = 1'b0;
        if (tick && state == UNLOCKED) begin
            if (has_cand) begin
                cnt_n = (cand_row == r_q && col == c_q) ? cnt + 3'd1 : 3'd1;
                r_n   = cand_row;
                c_n   = col;
                if (cnt_n == DEBOUNCE_SCANS) begin
                    key_n   = {2'b00, cand_row} * 4'd3 + {2'b00, col};
                    valid_n = 1'b1;
                    state_n = LOCKED;
                    cnt_n   = 3'd0;
                end
            end else if (col == c_q) begin
                cnt_n = 3'd0;
            end
        end else if (tick && col == c_q) begin
            cnt_n = kp.row[r_q] ? cnt + 3'd1 : 3'd0;
            if (cnt_n == DEBOUNCE_SCANS) begin
                state_n = UNLOCKED;
                cnt_n   = 3'd0;
            end
        end
    end

    assign kp.column    = column;
    assign kp.key       = key_q;
    assign kp.valid_key = valid_q;

    seg7_digit_decoder u_dec (
        .value(key_q),
        .seg  (kp.key_hex)
    );
endmodule

// File: tb/tb_keypad_scan_unit.sv
// tb_keypad_scan_unit: scoreboard bench for the keypad scanner with a fast scan rate
module tb_keypad_scan_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] held = 9'd0;
    logic [3:0] pend[$];
    int         errors = 0;
    int         checks = 0;
    int         pulses = 0;

    keypad_scan_unit_if kif ();

    keypad_scan_unit #(.SCAN_MAX(28'd4), .DEBOUNCE_SCANS(3'd2)) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kif)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] row_for(input logic [8:0] h, input logic [2:0] column);
        int c;
        logic [2:0] r;
        c = column == 3'b110 ? 0 : column == 3'b101 ? 1 : column == 3'b011 ? 2 : 3;
        r = 3'b111;
        for (int i = 0; i < 3; i++)
            if (c < 3 && h[i*3+c]) r[i] = 1'b0;
        return r;
    endfunction

    assign kif.row = row_for(held, kif.column);

    function automatic logic [6:0] seg_ref(input logic [3:0] k);
        logic [6:0] t[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return k < 4'd10 ? t[k] : 7'b1111111;
    endfunction

    function automatic logic [2:0] col_ref(input int idx);
        logic [2:0] t[3] = '{3'b110, 3'b101, 3'b011};
        return t[idx % 3];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (kif.valid_key === 1'b1) begin
            pulses++;
            if (pend.size() == 0) chk("spurious_pulse", kif.key, 32'hFFFF);
            else begin
                logic [3:0] e;
                e = pend.pop_front();
                chk("key", kif.key, e);
                chk("key_hex", kif.key_hex, seg_ref(e));
            end
        end
    end

    task automatic wait_col(input logic [2:0] c, input bit eq);
        int n = 0;
        while (((kif.column == c) != eq) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("col_wait", (kif.column == c) == eq, 1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (pend.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", pend.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(3);
        chk("rst_column", kif.column, 3'b110);
        chk("rst_valid", kif.valid_key, 0);
        chk("rst_key", kif.key, 4'hF);
        chk("rst_hex", kif.key_hex, 7'b1111111);
        reset = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk("scan_column", kif.column, col_ref(k / 5));
        end
        chk("idle_key", kif.key, 4'hF);
        chk("idle_pulses", pulses, 0);

        pend.push_back(4'd4);
        held = 9'b000010000;
        wait_drain(60);
        idle(45);
        chk("held_pulses", pulses, 1);
        held = 9'd0;
        idle(35);

        pend.push_back(4'd8);
        held = 9'b100000000;
        wait_drain(60);
        held = 9'd0;
        idle(35);
        chk("key8_hold", kif.key, 4'd8);

        pend.push_back(4'd0);
        held = 9'b001000001;
        wait_drain(60);
        idle(20);
        held = 9'd0;
        idle(35);
        chk("dual_pulses", pulses, 3);

        for (int i = 0; i < 3; i++) begin
            wait_col(3'b101, 1);
            held[4] = 1'b1;
            wait_col(3'b101, 0);
            held[4] = 1'b0;
            wait_col(3'b101, 1);
            wait_col(3'b101, 0);
        end
        chk("bounce_key", kif.key, 4'd0);
        chk("bounce_pulses", pulses, 3);

        wait_col(3'b101, 1);
        held[4] = 1'b1;
        wait_col(3'b101, 0);
        #2 reset = 1'b0;
        #1;
        chk("async_column", kif.column, 3'b110);
        chk("async_key", kif.key, 4'hF);
        chk("async_hex", kif.key_hex, 7'b1111111);
        chk("async_valid", kif.valid_key, 0);
        idle(3);
        reset = 1'b1;
        pend.push_back(4'd4);
        begin
            int k = 0;
            while (kif.valid_key !== 1'b1 && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk("rearm_latency", k, 25);
        end
        idle(45);
        held = 9'd0;
        idle(35);
        chk("total_pulses", pulses, 4);
        chk("queue_empty", pend.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
